dct_frame_sched: RTL and testbench
==================================

# dct_frame_sched

Frame-granular scheduler that shares one DCT datapath (pre-FFT reorder → FFT → vector rotation) between two Avalon-ST requester channels. It arbitrates whole frames round-robin and drives the per-frame `fftpts` configuration. It enforces frame length against `fftpts`, zero-padding short frames and truncating long ones. It also tags every frame in flight, so that DCT output frames are returned with the channel id that produced them.

## Interface
- `wData`, 16, sample width (real and imag) on all ports.
- `TAG_DEPTH`, 4, maximum frames in flight; power of 2, ≥2.

- `clk`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `reqN_valid` / `reqN_ready` (N = 0, 1)  in / out  1 / 1  requester handshake.
- `reqN_sop`, `reqN_eop`  in  1 each  requester frame delimiters.
- `reqN_real`, `reqN_imag`  in  `wData` each  requester sample.
- `reqN_fftpts`  in  12  frame length; sampled with the sop beat.
- `dct_sink_valid`, `dct_sink_ready`  out, in  1, 1  handshake toward the DCT sink.
- `dct_sink_sop`, `dct_sink_eop`  out  1 each  DCT sink frame delimiters.
- `dct_sink_error`  out  2  DCT sink error code.
- `dct_sink_real`, `dct_sink_imag`  out  `wData` each  DCT sink sample.
- `dct_fftpts`  out  12  frame length to the DCT; held stable for the whole frame.
- `dct_src_valid`, `dct_src_ready`, `dct_src_sop`, `dct_src_eop`, `dct_src_error`, `dct_src_real`, `dct_src_imag`  in/out mix  from the DCT source.
- `out_valid`, `out_ready`, `out_sop`, `out_eop`, `out_error`, `out_real`, `out_imag`  out/in mix  DCT source passed through to the consumer.
- `out_chan`  out  1  channel id of the current output frame.
- `err_flags`  out  4  sticky error flags: [0] short frame, [1] long frame, [2] illegal `fftpts`, [3] output with no tag. Cleared only by reset.

## Operation
- States: IDLE, XFER, PAD, DROP, REJECT.

- **IDLE**
  - A requester is eligible when `reqN_valid` and `reqN_sop` are high.
  - Grant requires the tag FIFO to be not full.
  - Round-robin: the last-granted channel loses a tie. The priority pointer resets to 1, so ch0 wins the first tie.
  - Grant actions: latch `fftpts` and channel, push channel to the tag FIFO, go to XFER. No beat is consumed on the grant cycle.
  - A valid non-sop beat in IDLE is consumed (`reqN_ready` = 1) and dropped. It does not set an error flag.
  - A requester that is not granted sees `reqN_ready` = 0.

- **Legal `fftpts`:** power of 2 in 8..2048. An illegal value enters REJECT instead of XFER, with no tag push and `err_flags[2]` set.

- **XFER** (combinational passthrough from the granted requester)
  - `dct_sink_valid` = `reqG_valid`; `reqG_ready` = `dct_sink_ready`.
  - `dct_sink_sop` = (cnt == 0); `dct_sink_eop` = (cnt == fftpts−1); `dct_sink_error` = 0.
  - `cnt` increments on each sink handshake.
  - Requester eop at cnt < fftpts−1: the beat is forwarded with `dct_sink_eop` = 0, `err_flags[0]` is set, go to PAD.
  - Beat at cnt == fftpts−1:
    - with `reqG_eop` = 1 → IDLE;
    - with `reqG_eop` = 0 → forced eop, `dct_sink_error` = 2'b10, `err_flags[1]` set, go to DROP.

- **PAD**
  - Drives zero samples, `dct_sink_valid` = 1, until cnt == fftpts−1.
  - The final beat carries eop and `dct_sink_error` = 2'b01, then → IDLE.
  - `reqG_ready` = 0 throughout.

- **DROP / REJECT**
  - `reqG_ready` = 1; beats are discarded; `dct_sink_valid` = 0.
  - Leave for IDLE on the accepted `reqG_eop` beat.

- **Output side**
  - `out_*` equals `dct_src_*` combinationally; `dct_src_ready` = `out_ready`.
  - `out_chan` = tag FIFO head.
  - The tag FIFO pops on a `dct_src` handshake with eop.
  - Output valid while the FIFO is empty: `out_chan` = 0 and `err_flags[3]` is set.
  - A grant push and an output pop in the same cycle are both performed; the count is unchanged.

## Timing
- Grant takes 1 cycle: a sop presented at cycle t is forwarded to the DCT sink at the earliest at t+1.
- After a frame's last handshake at cycle t, the next grant decision is made at t+1 and its first beat moves at t+2.
- Passthrough adds zero cycles of latency and no bubbles inside a frame.
- Reset (asynchronous, may hit mid-frame):
  - state → IDLE, cnt → 0, tag FIFO emptied, priority pointer → 1, `err_flags` → 0;
  - all valid/ready outputs → 0;
  - `dct_fftpts`, `dct_sink_real`/`imag`/`sop`/`eop`/`error` → 0.
- `dct_fftpts` changes only on a grant cycle.

## Structure
- Shared package `dct_pkg`:
  - state enum;
  - error code constants (2'b01 pad, 2'b10 truncate);
  - `FFTPTS_MIN` = 8, `FFTPTS_MAX` = 2048;
  - legal-`fftpts` check function.
- One sub-module: `dct_tag_fifo`, a 1-bit × `TAG_DEPTH` synchronous FIFO with full, empty and simultaneous push/pop support.

## Test plan
- **Single frame:** ch0 sends 8 beats (1..8) with `fftpts` = 8 → `dct_sink` shows 8 beats, sop on beat 1, eop on beat 8, error 0. The returned DCT frame carries `out_chan` = 0.
- **Tie:** ch0 and ch1 both present sop in the same cycle, `fftpts` = 16 each → ch0 is granted first, then ch1. Outputs come back tagged 0 then 1.
- **Short frame:** ch1 sends eop on beat 5 with `fftpts` = 8 → 3 zero beats follow, the last with eop and error 2'b01. `err_flags` = 4'b0001.
- **Long frame:** ch0 sends 10 beats with `fftpts` = 8 → eop is forced on beat 8 with error 2'b10. Beats 9–10 are dropped. `err_flags[1]` is set.
- **Illegal `fftpts` = 12:** the whole frame is consumed, `dct_sink_valid` stays 0, no tag is pushed, `err_flags[2]` is set.
- **Backpressure and reset:** with `TAG_DEPTH` = 4, 4 frames are granted while `out_ready` = 0 → a 5th sop waits with `req_ready` = 0 until one output eop pops a tag. Asserting `reset_n` low mid-frame → all outputs read 0 on the same cycle.

Source files
------------

// File: rtl/dct_pkg.sv
// Shared types and constants for the DCT frame scheduler.
//   state_e       : scheduler FSM states
//   ERR_*         : dct_sink_error codes (pad / truncate)
//   FFTPTS_*      : fftpts width and legal range
//   fftpts_legal  : power of 2 within FFTPTS_MIN..FFTPTS_MAX
package dct_pkg;

  localparam int unsigned FFTPTS_W   = 12;
  localparam int unsigned FFTPTS_MIN = 8;
  localparam int unsigned FFTPTS_MAX = 2048;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_PAD   = 2'b01;
  localparam logic [1:0] ERR_TRUNC = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_XFER,
    ST_PAD,
    ST_DROP,
    ST_REJECT
  } state_e;

  // Legal frame length: single bit set, inside the supported range.
  function automatic logic fftpts_legal(input logic [FFTPTS_W-1:0] pts);
    return (pts >= FFTPTS_W'(FFTPTS_MIN)) &&
           (pts <= FFTPTS_W'(FFTPTS_MAX)) &&
           ((pts & (pts - FFTPTS_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/dct_tag_fifo.sv
// 1-bit wide channel-tag FIFO for frames in flight through the DCT.
//   push/push_data : write a tag (accepted when not full, or when popping)
//   pop/pop_data   : head tag is pop_data; pop ignored when empty
//   full/empty     : occupancy status
module dct_tag_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push,
  input  logic push_data,
  input  logic pop,
  output logic pop_data,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign do_pop   = pop & ~empty;
  // A pop frees the slot in the same cycle, so push is allowed even when full.
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem_q[rd_ptr_q];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/dct_frame_sched.sv
// Frame-granular round-robin scheduler sharing one DCT datapath between two
// Avalon-ST requesters, with frame-length enforcement and output tagging.
//   req0_* / req1_*  : requester streams (fftpts sampled with the sop beat)
//   dct_sink_*       : stream into the DCT, dct_fftpts held per frame
//   dct_src_*        : stream out of the DCT
//   out_*, out_chan  : DCT output passed through, tagged with its channel
//   err_flags        : sticky {no-tag output, illegal fftpts, long, short}
module dct_frame_sched
  import dct_pkg::*;
#(
  parameter int unsigned wData     = 16,
  parameter int unsigned TAG_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic                req0_sop,
  input  logic                req0_eop,
  input  logic [wData-1:0]    req0_real,
  input  logic [wData-1:0]    req0_imag,
  input  logic [FFTPTS_W-1:0] req0_fftpts,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic                req1_sop,
  input  logic                req1_eop,
  input  logic [wData-1:0]    req1_real,
  input  logic [wData-1:0]    req1_imag,
  input  logic [FFTPTS_W-1:0] req1_fftpts,
  output logic                dct_sink_valid,
  input  logic                dct_sink_ready,
  output logic                dct_sink_sop,
  output logic                dct_sink_eop,
  output logic [1:0]          dct_sink_error,
  output logic [wData-1:0]    dct_sink_real,
  output logic [wData-1:0]    dct_sink_imag,
  output logic [FFTPTS_W-1:0] dct_fftpts,
  input  logic                dct_src_valid,
  output logic                dct_src_ready,
  input  logic                dct_src_sop,
  input  logic                dct_src_eop,
  input  logic [1:0]          dct_src_error,
  input  logic [wData-1:0]    dct_src_real,
  input  logic [wData-1:0]    dct_src_imag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_sop,
  output logic                out_eop,
  output logic [1:0]          out_error,
  output logic [wData-1:0]    out_real,
  output logic [wData-1:0]    out_imag,
  output logic                out_chan,
  output logic [3:0]          err_flags
);

  state_e              state_q, state_d;
  logic [FFTPTS_W-1:0] cnt_q, cnt_d;
  logic                chan_q;      // channel owning the current frame
  logic                last_q;      // last granted channel (loses ties)
  logic [3:0]          err_set;

  logic                elig0, elig1;
  logic                grant_any, grant_chan, grant_legal;
  logic [FFTPTS_W-1:0] grant_pts;
  logic                cnt_last, sink_hs, sel_ready;
  logic                sel_valid, sel_eop;
  logic [wData-1:0]    sel_real, sel_imag;
  logic                tag_push, tag_pop, tag_head, tag_full, tag_empty;

  // Granted requester view.
  assign sel_valid = chan_q ? req1_valid : req0_valid;
  assign sel_eop   = chan_q ? req1_eop   : req0_eop;
  assign sel_real  = chan_q ? req1_real  : req0_real;
  assign sel_imag  = chan_q ? req1_imag  : req0_imag;

  // Whole-frame round-robin arbitration.
  assign elig0       = req0_valid & req0_sop;
  assign elig1       = req1_valid & req1_sop;
  assign grant_chan  = (elig0 & elig1) ? ~last_q : elig1;
  assign grant_any   = (state_q == ST_IDLE) & (elig0 | elig1) & ~tag_full;
  assign grant_pts   = grant_chan ? req1_fftpts : req0_fftpts;
  assign grant_legal = fftpts_legal(grant_pts);

  assign cnt_last = (cnt_q == (dct_fftpts - FFTPTS_W'(1)));
  assign sink_hs  = dct_sink_valid & dct_sink_ready;

  // Output side: passthrough; valid/ready forced low while in reset.
  assign out_valid     = dct_src_valid & reset_n;
  assign dct_src_ready = out_ready & reset_n;
  assign out_sop       = dct_src_sop;
  assign out_eop       = dct_src_eop;
  assign out_error     = dct_src_error;
  assign out_real      = dct_src_real;
  assign out_imag      = dct_src_imag;
  assign out_chan      = tag_empty ? 1'b0 : tag_head;
  assign tag_pop       = out_valid & dct_src_ready & dct_src_eop;

  dct_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (tag_push),
    .push_data (grant_chan),
    .pop       (tag_pop),
    .pop_data  (tag_head),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  // State register and per-frame configuration.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      chan_q     <= 1'b0;
      last_q     <= 1'b1;
      dct_fftpts <= '0;
      err_flags  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_flags <= err_flags | err_set;
      if (grant_any) begin
        chan_q <= grant_chan;
        last_q <= grant_chan;
        if (grant_legal) begin
          dct_fftpts <= grant_pts;
        end
      end
    end
  end

  // Next-state, beat counter, tag push and error events.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tag_push = 1'b0;
    err_set  = {out_valid & tag_empty, 3'b000};
    unique case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          cnt_d      = '0;
          tag_push   = grant_legal;
          err_set[2] = ~grant_legal;
          state_d    = grant_legal ? ST_XFER : ST_REJECT;
        end
      end
      ST_XFER: begin
        if (sink_hs) begin
          cnt_d = cnt_q + FFTPTS_W'(1);
          if (cnt_last) begin
            cnt_d = '0;
            if (sel_eop) begin
              state_d = ST_IDLE;
            end else begin
              err_set[1] = 1'b1;
              state_d    = ST_DROP;
            end
          end else if (sel_eop) begin
            err_set[0] = 1'b1;
            state_d    = ST_PAD;
          end
        end
      end
      ST_PAD: begin
        if (sink_hs) begin
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + FFTPTS_W'(1);
          end
        end
      end
      ST_DROP, ST_REJECT: begin
        if (sel_valid & sel_eop) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sink stream and requester ready per state.
  always_comb begin
    dct_sink_valid = 1'b0;
    dct_sink_sop   = 1'b0;
    dct_sink_eop   = 1'b0;
    dct_sink_error = ERR_NONE;
    dct_sink_real  = '0;
    dct_sink_imag  = '0;
    sel_ready      = 1'b0;
    req0_ready     = 1'b0;
    req1_ready     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Stray mid-frame beats are swallowed; sop beats wait for a grant.
        req0_ready = req0_valid & ~req0_sop;
        req1_ready = req1_valid & ~req1_sop;
      end
      ST_XFER: begin
        dct_sink_valid = sel_valid;
        dct_sink_sop   = (cnt_q == '0);
        dct_sink_eop   = cnt_last;
        dct_sink_error = (cnt_last & ~sel_eop) ? ERR_TRUNC : ERR_NONE;
        dct_sink_real  = sel_real;
        dct_sink_imag  = sel_imag;
        sel_ready      = dct_sink_ready;
      end
      ST_PAD: begin
        dct_sink_valid = 1'b1;
        dct_sink_eop   = cnt_last;
        dct_sink_error = cnt_last ? ERR_PAD : ERR_NONE;
      end
      ST_DROP, ST_REJECT: begin
        sel_ready = 1'b1;
      end
      default: ;
    endcase
    if (state_q != ST_IDLE) begin
      req0_ready = ~chan_q & sel_ready;
      req1_ready = chan_q & sel_ready;
    end
    if (!reset_n) begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
  end

endmodule

// File: tb/tb_dct_frame_sched.sv
// Directed bench for dct_frame_sched: requester/DCT-source drivers, a sink
// beat monitor, and hand-computed expectations checked with assertions.
module tb_dct_frame_sched;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0_valid, req0_ready, req0_sop, req0_eop;
  logic [15:0] req0_real, req0_imag;
  logic [11:0] req0_fftpts;
  logic        req1_valid, req1_ready, req1_sop, req1_eop;
  logic [15:0] req1_real, req1_imag;
  logic [11:0] req1_fftpts;
  logic        dct_sink_valid, dct_sink_ready, dct_sink_sop, dct_sink_eop;
  logic [1:0]  dct_sink_error;
  logic [15:0] dct_sink_real, dct_sink_imag;
  logic [11:0] dct_fftpts;
  logic        dct_src_valid, dct_src_ready, dct_src_sop, dct_src_eop;
  logic [1:0]  dct_src_error;
  logic [15:0] dct_src_real, dct_src_imag;
  logic        out_valid, out_ready, out_sop, out_eop, out_chan;
  logic [1:0]  out_error;
  logic [15:0] out_real, out_imag;
  logic [3:0]  err_flags;

  int vectors;
  int miscompares;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [1:0]  err;
    logic [15:0] re;
    logic [15:0] im;
    logic [31:0] cyc;
  } beat_t;

  beat_t       sq[$];
  beat_t       mon_b;
  logic [31:0] cyc = '0;
  logic [31:0] sop_cyc [2];

  dct_frame_sched #(
    .wData     (16),
    .TAG_DEPTH (4)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req0_valid     (req0_valid),
    .req0_ready     (req0_ready),
    .req0_sop       (req0_sop),
    .req0_eop       (req0_eop),
    .req0_real      (req0_real),
    .req0_imag      (req0_imag),
    .req0_fftpts    (req0_fftpts),
    .req1_valid     (req1_valid),
    .req1_ready     (req1_ready),
    .req1_sop       (req1_sop),
    .req1_eop       (req1_eop),
    .req1_real      (req1_real),
    .req1_imag      (req1_imag),
    .req1_fftpts    (req1_fftpts),
    .dct_sink_valid (dct_sink_valid),
    .dct_sink_ready (dct_sink_ready),
    .dct_sink_sop   (dct_sink_sop),
    .dct_sink_eop   (dct_sink_eop),
    .dct_sink_error (dct_sink_error),
    .dct_sink_real  (dct_sink_real),
    .dct_sink_imag  (dct_sink_imag),
    .dct_fftpts     (dct_fftpts),
    .dct_src_valid  (dct_src_valid),
    .dct_src_ready  (dct_src_ready),
    .dct_src_sop    (dct_src_sop),
    .dct_src_eop    (dct_src_eop),
    .dct_src_error  (dct_src_error),
    .dct_src_real   (dct_src_real),
    .dct_src_imag   (dct_src_imag),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_sop        (out_sop),
    .out_eop        (out_eop),
    .out_error      (out_error),
    .out_real       (out_real),
    .out_imag       (out_imag),
    .out_chan       (out_chan),
    .err_flags      (err_flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  // Record every accepted sink beat with its cycle number.
  always @(negedge clk) begin
    if (reset_n && dct_sink_valid && dct_sink_ready) begin
      mon_b.sop = dct_sink_sop;
      mon_b.eop = dct_sink_eop;
      mon_b.err = dct_sink_error;
      mon_b.re  = dct_sink_real;
      mon_b.im  = dct_sink_imag;
      mon_b.cyc = cyc;
      sq.push_back(mon_b);
    end
  end

  function automatic beat_t sq_at(input int i);
    if (i < sq.size()) return sq[i];
    return '0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int ch, input logic v, input logic s, input logic e,
                         input logic [15:0] d, input logic [11:0] p);
    if (ch == 0) begin
      req0_valid = v; req0_sop = s; req0_eop = e;
      req0_real = d; req0_imag = ~d; req0_fftpts = p;
    end else begin
      req1_valid = v; req1_sop = s; req1_eop = e;
      req1_real = d; req1_imag = ~d; req1_fftpts = p;
    end
  endtask

  // Send n beats base, base+1, ... on channel ch; eop on the last beat.
  task automatic send(input int ch, input int n, input logic [11:0] pts, input logic [15:0] base);
    int   guard;
    logic rdy;
    logic to;
    to = 1'b0;
    for (int i = 0; i < n && !to; i++) begin
      set_req(ch, 1'b1, i == 0, i == n - 1, base + 16'(i), pts);
      guard = 0;
      forever begin
        @(negedge clk);
        if (i == 0 && guard == 0) sop_cyc[ch] = cyc;
        rdy = (ch == 0) ? req0_ready : req1_ready;
        if (rdy) break;
        guard++;
        if (guard > 200) begin
          to = 1'b1;
          break;
        end
      end
      @(posedge clk); #1;
    end
    set_req(ch, 1'b0, 1'b0, 1'b0, 16'h0, 12'h0);
    check("send_timeout", 32'(to), 32'd0);
  endtask

  // Return one n-beat DCT frame; checks the tag and passthrough on its first beat.
  task automatic ret_frame(input int n, input logic exp_chan, input string tag);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      dct_src_valid = 1'b1;
      dct_src_sop   = (i == 0);
      dct_src_eop   = (i == n - 1);
      dct_src_real  = 16'(i);
      dct_src_imag  = 16'h0;
      dct_src_error = 2'b00;
      @(negedge clk);
      if (i == 0) begin
        check({tag, "_chan"}, 32'(out_chan), 32'(exp_chan));
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_pass"}, {13'h0, out_sop, out_eop, out_error, out_real ^ out_imag},
              {13'h0, 1'b1, (n == 1), 2'b00, 16'h0});
      end
      @(posedge clk); #1;
    end
    dct_src_valid = 1'b0;
    dct_src_sop   = 1'b0;
    dct_src_eop   = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    beat_t b;
    vectors     = 0;
    miscompares = 0;

    // Reset: outputs quiet even with a valid DCT source and ready consumer.
    reset_n = 1'b0;
    set_req(0, 1'b0, 1'b0, 1'b0, 16'h0, 12'h0);
    set_req(1, 1'b0, 1'b0, 1'b0, 16'h0, 12'h0);
    dct_sink_ready = 1'b1;
    dct_src_valid  = 1'b1;
    dct_src_sop    = 1'b0;
    dct_src_eop    = 1'b0;
    dct_src_error  = 2'b00;
    dct_src_real   = 16'h0;
    dct_src_imag   = 16'h0;
    out_ready      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_err_flags", 32'(err_flags), 32'h0);
    check("rst_fftpts", 32'(dct_fftpts), 32'h0);
    check("rst_sink_valid", 32'(dct_sink_valid), 32'h0);
    check("rst_req_ready", {30'h0, req1_ready, req0_ready}, 32'h0);
    check("rst_out_vr", {30'h0, out_valid, dct_src_ready}, 32'h0);
    dct_src_valid = 1'b0;
    out_ready     = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Tie: ch0 wins first, ch1 follows two cycles after ch0's last beat.
    sq.delete();
    fork
      send(0, 16, 12'd16, 16'd100);
      send(1, 16, 12'd16, 16'd200);
    join
    check("tie_count", 32'(sq.size()), 32'd32);
    b = sq_at(0);
    check("tie_b0", {12'h0, b.sop, b.eop, b.err, b.re}, {12'h0, 1'b1, 1'b0, 2'b00, 16'd100});
    check("tie_b0_im", 32'(b.im), 32'h0000FF9B);
    check("tie_grant_lat", b.cyc - sop_cyc[0], 32'd1);
    b = sq_at(15);
    check("tie_b15", {12'h0, b.sop, b.eop, b.err, b.re}, {12'h0, 1'b0, 1'b1, 2'b00, 16'd115});
    b = sq_at(16);
    check("tie_b16", {12'h0, b.sop, b.eop, b.err, b.re}, {12'h0, 1'b1, 1'b0, 2'b00, 16'd200});
    check("tie_gap", sq_at(16).cyc - sq_at(15).cyc, 32'd2);
    check("tie_fftpts", 32'(dct_fftpts), 32'd16);
    ret_frame(2, 1'b0, "tie_out0");
    ret_frame(2, 1'b1, "tie_out1");

    // Single legal frame on ch0.
    sq.delete();
    send(0, 8, 12'd8, 16'd1);
    check("single_count", 32'(sq.size()), 32'd8);
    b = sq_at(0);
    check("single_b0", {12'h0, b.sop, b.eop, b.err, b.re}, {12'h0, 1'b1, 1'b0, 2'b00, 16'd1});
    check("single_lat", b.cyc - sop_cyc[0], 32'd1);
    b = sq_at(3);
    check("single_b3", {12'h0, b.sop, b.eop, b.err, b.re}, {12'h0, 1'b0, 1'b0, 2'b00, 16'd4});
    b = sq_at(7);
    check("single_b7", {12'h0, b.sop, b.eop, b.err, b.re}, {12'h0, 1'b0, 1'b1, 2'b00, 16'd8});
    check("single_fftpts", 32'(dct_fftpts), 32'd8);
    check("single_err", 32'(err_flags), 32'h0);
    ret_frame(1, 1'b0, "single_out");

    // Short frame on ch1: 5 beats, 3 zero pad beats.
    sq.delete();
    send(1, 5, 12'd8, 16'd50);
    repeat (4) @(posedge clk);
    #1;
    check("short_count", 32'(sq.size()), 32'd8);
    b = sq_at(4);
    check("short_b4", {12'h0, b.sop, b.eop, b.err, b.re}, {12'h0, 1'b0, 1'b0, 2'b00, 16'd54});
    b = sq_at(5);
    check("short_b5", {12'h0, b.sop, b.eop, b.err, b.re}, {12'h0, 1'b0, 1'b0, 2'b00, 16'd0});
    b = sq_at(7);
    check("short_b7", {12'h0, b.sop, b.eop, b.err, b.re}, {12'h0, 1'b0, 1'b1, 2'b01, 16'd0});
    check("short_err", 32'(err_flags), 32'h1);
    ret_frame(1, 1'b1, "short_out");

    // Long frame on ch0: truncated at 8, beats 9-10 dropped.
    sq.delete();
    send(0, 10, 12'd8, 16'd70);
    check("long_count", 32'(sq.size()), 32'd8);
    b = sq_at(7);
    check("long_b7", {12'h0, b.sop, b.eop, b.err, b.re}, {12'h0, 1'b0, 1'b1, 2'b10, 16'd77});
    check("long_err", 32'(err_flags), 32'h3);
    ret_frame(1, 1'b0, "long_out");

    // Illegal fftpts on ch1: whole frame swallowed, nothing to the sink.
    sq.delete();
    send(1, 4, 12'd12, 16'd90);
    check("illegal_count", 32'(sq.size()), 32'd0);
    check("illegal_err", 32'(err_flags), 32'h7);

    // Backpressure: four tags fill the FIFO; ch1 waits until one pops.
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(0, 8, 12'd8, 16'(k * 16));
    sq.delete();
    fork
      send(1, 8, 12'd8, 16'd300);
      begin
        repeat (3) @(negedge clk);
        check("bp_req1_ready", 32'(req1_ready), 32'd0);
        check("bp_sink_valid", 32'(dct_sink_valid), 32'd0);
        @(posedge clk); #1;
        ret_frame(1, 1'b0, "bp_pop");
      end
    join
    check("bp_count", 32'(sq.size()), 32'd8);
    check("bp_b0_re", 32'(sq_at(0).re), 32'd300);
    check("bp_wait", sq_at(0).cyc - sop_cyc[1], 32'd5);
    ret_frame(2, 1'b0, "drain0");
    ret_frame(1, 1'b0, "drain1");
    ret_frame(1, 1'b0, "drain2");
    ret_frame(1, 1'b1, "drain3");

    // Output with no tag outstanding.
    ret_frame(1, 1'b0, "notag");
    check("notag_err", 32'(err_flags), 32'hF);

    // Asynchronous reset in the middle of a frame.
    set_req(0, 1'b1, 1'b1, 1'b0, 16'h0055, 12'd8);
    @(posedge clk); #1;
    dct_src_valid = 1'b1;
    out_ready     = 1'b1;
    @(negedge clk);
    check("mid_sink_valid", 32'(dct_sink_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_sink", {12'h0, dct_sink_valid, dct_sink_sop, dct_sink_eop, dct_sink_error,
                           dct_sink_real ^ dct_sink_imag}, 32'h0);
    check("mid_rst_ready", {30'h0, req1_ready, req0_ready}, 32'h0);
    check("mid_rst_out", {30'h0, out_valid, dct_src_ready}, 32'h0);
    check("mid_rst_cfg", {16'h0, err_flags, dct_fftpts}, 32'h0);
    dct_src_valid = 1'b0;
    @(posedge clk); #1;
    req0_sop = 1'b0;
    reset_n  = 1'b1;
    #1;
    check("post_rst_idle_drop", 32'(req0_ready), 32'd1);
    set_req(0, 1'b0, 1'b0, 1'b0, 16'h0, 12'h0);
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
